// File: rtl/ula_pkg.sv
// Shared definitions for the shared-ALU scheduler: func codes, FSM encoding,
// default multicycle latencies and the two special operand values for divide.
package ula_pkg;

    localparam logic [3:0] FUNC_ADD = 4'b0000;
    localparam logic [3:0] FUNC_SUB = 4'b0001;
    localparam logic [3:0] FUNC_MUL = 4'b0010;
    localparam logic [3:0] FUNC_DIV = 4'b0011;
    localparam logic [3:0] FUNC_AND = 4'b0100;
    localparam logic [3:0] FUNC_OR  = 4'b0101;

    localparam int DEF_MUL_LAT = 2;
    localparam int DEF_DIV_LAT = 4;

    localparam logic [31:0] INT_MIN = 32'h8000_0000;
    localparam logic [31:0] NEG_ONE = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    function automatic logic is_valid_func(input logic [3:0] func);
        return (func <= FUNC_OR);
    endfunction

endpackage

// File: rtl/ula_sched_ula.sv
// Combinational ALU shared by both requesters; returns raw result and raw
// signed overflow, which the scheduler may override.
module ula
    import ula_pkg::*;
(
    input  logic [3:0]  func,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] result,
    output logic        overflow
);

    logic [31:0]        sum;
    logic [31:0]        diff;
    logic [31:0]        product;
    logic [31:0]        safe_b;
    logic signed [31:0] quotient;

    assign sum     = a + b;
    assign diff    = a - b;
    assign product = a * b;

    // Substitute a harmless divisor for the cases the scheduler handles itself,
    // so the divider never sees a trapping operand pair.
    assign safe_b   = ((b == 32'd0) || ((a == INT_MIN) && (b == NEG_ONE))) ? 32'd1 : b;
    assign quotient = $signed(a) / $signed(safe_b);

    always_comb begin
        result   = 32'd0;
        overflow = 1'b0;
        case (func)
            FUNC_ADD: begin
                result   = sum;
                overflow = (a[31] == b[31]) && (sum[31] != a[31]);
            end
            FUNC_SUB: begin
                result   = diff;
                overflow = (a[31] != b[31]) && (diff[31] != a[31]);
            end
            FUNC_MUL: result = product;
            FUNC_DIV: result = quotient;
            FUNC_AND: result = a & b;
            FUNC_OR:  result = a | b;
            default: begin
                result   = 32'd0;
                overflow = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/ula_sched.sv
// Round-robin scheduler giving two requesters access to one multicycle ALU,
// returning each result with cleaned-up flags over a valid/ready channel.
module ula_sched
    import ula_pkg::*;
#(
    parameter int MUL_LAT = DEF_MUL_LAT,
    parameter int DIV_LAT = DEF_DIV_LAT
) (
    input  logic        clk,
    input  logic        rst_n,

    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [3:0]  req0_func,
    input  logic [31:0] req0_a,
    input  logic [31:0] req0_b,

    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [3:0]  req1_func,
    input  logic [31:0] req1_a,
    input  logic [31:0] req1_b,

    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic        rsp_id,
    output logic [31:0] rsp_result,
    output logic        rsp_overflow,
    output logic        rsp_zero,
    output logic        rsp_error,

    output logic        busy
);

    localparam int MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
    localparam int CNT_W   = $clog2(MAX_LAT) + 1;

    state_t             state;
    state_t             next_state;

    logic               last;
    logic               grant;
    logic               accept;
    logic               finish;

    logic [3:0]         sel_func;
    logic [31:0]        sel_a;
    logic [31:0]        sel_b;
    logic [CNT_W-1:0]   load_cnt;

    logic [3:0]         op_func;
    logic [31:0]        op_a;
    logic [31:0]        op_b;
    logic               op_id;
    logic [CNT_W-1:0]   cnt;

    logic [31:0]        alu_result;
    logic               alu_overflow;

    logic [31:0]        fin_result;
    logic               fin_overflow;
    logic               fin_error;

    // Contested requests go to the port not served last; otherwise to whoever asks.
    always_comb begin
        grant = 1'b0;
        if (req0_valid && req1_valid) begin
            grant = ~last;
        end else if (req1_valid) begin
            grant = 1'b1;
        end
    end

    assign sel_func = grant ? req1_func : req0_func;
    assign sel_a    = grant ? req1_a    : req0_a;
    assign sel_b    = grant ? req1_b    : req0_b;

    always_comb begin
        load_cnt = '0;
        case (sel_func)
            FUNC_MUL: load_cnt = CNT_W'(MUL_LAT - 1);
            FUNC_DIV: load_cnt = CNT_W'(DIV_LAT - 1);
            default:  load_cnt = '0;
        endcase
    end

    always_comb begin
        next_state = state;
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        accept     = 1'b0;
        finish     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (rst_n && (req0_valid || req1_valid)) begin
                    accept     = 1'b1;
                    req0_ready = ~grant;
                    req1_ready = grant;
                    next_state = ST_EXEC;
                end
            end
            ST_EXEC: begin
                if (cnt == '0) begin
                    finish     = 1'b1;
                    next_state = ST_RESP;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    next_state = ST_IDLE;
                end
            end
            default: next_state = ST_IDLE;
        endcase
    end

    ula u_ula (
        .func     (op_func),
        .a        (op_a),
        .b        (op_b),
        .result   (alu_result),
        .overflow (alu_overflow)
    );

    // Divide corner cases are resolved here; the ALU quotient is ignored for them.
    always_comb begin
        fin_result   = alu_result;
        fin_overflow = 1'b0;
        fin_error    = 1'b0;
        if (!is_valid_func(op_func)) begin
            fin_result = 32'd0;
            fin_error  = 1'b1;
        end else if (op_func == FUNC_DIV) begin
            if (op_b == 32'd0) begin
                fin_result   = 32'd0;
                fin_overflow = 1'b1;
            end else if ((op_a == INT_MIN) && (op_b == NEG_ONE)) begin
                fin_result   = INT_MIN;
                fin_overflow = 1'b1;
            end
        end else if ((op_func == FUNC_ADD) || (op_func == FUNC_SUB)) begin
            fin_overflow = alu_overflow;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= ST_IDLE;
            last         <= 1'b1;
            op_func      <= 4'd0;
            op_a         <= 32'd0;
            op_b         <= 32'd0;
            op_id        <= 1'b0;
            cnt          <= '0;
            rsp_id       <= 1'b0;
            rsp_result   <= 32'd0;
            rsp_overflow <= 1'b0;
            rsp_zero     <= 1'b0;
            rsp_error    <= 1'b0;
        end else begin
            state <= next_state;
            if (accept) begin
                op_func <= sel_func;
                op_a    <= sel_a;
                op_b    <= sel_b;
                op_id   <= grant;
                last    <= grant;
                cnt     <= load_cnt;
            end else if ((state == ST_EXEC) && (cnt != '0)) begin
                cnt <= cnt - 1'b1;
            end
            if (finish) begin
                rsp_id       <= op_id;
                rsp_result   <= fin_result;
                rsp_overflow <= fin_overflow;
                rsp_zero     <= (fin_result == 32'd0);
                rsp_error    <= fin_error;
            end
        end
    end

    assign rsp_valid = (state == ST_RESP);
    assign busy      = (state != ST_IDLE);

endmodule

// File: tb/tb_ula_sched.sv
// Directed bench for ula_sched: arbitration order, latencies, flag overrides,
// response back-pressure and reset in mid-operation.
module tb_ula_sched;
    import ula_pkg::*;

    localparam int MUL_LAT = 2;
    localparam int DIV_LAT = 4;

    logic        clk;
    logic        rst_n;
    logic        req0_valid, req0_ready;
    logic [3:0]  req0_func;
    logic [31:0] req0_a, req0_b;
    logic        req1_valid, req1_ready;
    logic [3:0]  req1_func;
    logic [31:0] req1_a, req1_b;
    logic        rsp_valid, rsp_ready, rsp_id;
    logic [31:0] rsp_result;
    logic        rsp_overflow, rsp_zero, rsp_error;
    logic        busy;

    int numChecks = 0;
    int numFails  = 0;

    ula_sched #(.MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req0_valid   (req0_valid),
        .req0_ready   (req0_ready),
        .req0_func    (req0_func),
        .req0_a       (req0_a),
        .req0_b       (req0_b),
        .req1_valid   (req1_valid),
        .req1_ready   (req1_ready),
        .req1_func    (req1_func),
        .req1_a       (req1_a),
        .req1_b       (req1_b),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_id       (rsp_id),
        .rsp_result   (rsp_result),
        .rsp_overflow (rsp_overflow),
        .rsp_zero     (rsp_zero),
        .rsp_error    (rsp_error),
        .busy         (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        numChecks++;
        if (observed !== expected) begin
            numFails++;
            $display("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input int port, input logic [3:0] func, input logic [31:0] a, input logic [31:0] b);
        if (port == 0) begin
            req0_valid = 1'b1; req0_func = func; req0_a = a; req0_b = b;
        end else begin
            req1_valid = 1'b1; req1_func = func; req1_a = a; req1_b = b;
        end
    endtask

    task automatic resetDut();
        rst_n      = 1'b0;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        rsp_ready  = 1'b1;
        tick();
        tick();
        req0_valid = 1'b1;
        #1;
        checkOutput("reset_ready0", {31'd0, req0_ready}, 32'd0);
        checkOutput("reset_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        checkOutput("reset_busy", {31'd0, busy}, 32'd0);
        checkOutput("reset_result", rsp_result, 32'd0);
        checkOutput("reset_flags", {28'd0, rsp_id, rsp_overflow, rsp_zero, rsp_error}, 32'd0);
        req0_valid = 1'b0;
        rst_n      = 1'b1;
    endtask

    // Expects the given port to be granted in the current cycle, then takes the handshake.
    task automatic acceptOn(input int port, input string tag);
        #1;
        checkOutput({tag, "_ready"}, {30'd0, req1_ready, req0_ready}, (port == 0) ? 32'd1 : 32'd2);
        tick();
        if (port == 0) req0_valid = 1'b0;
        else           req1_valid = 1'b0;
        checkOutput({tag, "_busy"}, {31'd0, busy}, 32'd1);
    endtask

    task automatic waitResponse(input string tag, input int expLat, input logic expId,
                                input logic [31:0] expRes, input logic expOv,
                                input logic expZero, input logic expErr);
        int cyc = 1;
        while (!rsp_valid && cyc < 40) begin
            tick();
            cyc++;
        end
        checkOutput({tag, "_latency"}, cyc, expLat + 1);
        checkOutput({tag, "_result"}, rsp_result, expRes);
        checkOutput({tag, "_flags"}, {28'd0, rsp_id, rsp_overflow, rsp_zero, rsp_error},
                    {28'd0, expId, expOv, expZero, expErr});
        checkOutput({tag, "_busy"}, {31'd0, busy}, 32'd1);
    endtask

    task automatic oneOp(input string tag, input logic [3:0] func, input logic [31:0] a, input logic [31:0] b,
                         input int expLat, input logic [31:0] expRes, input logic expOv,
                         input logic expZero, input logic expErr);
        applyStimulus(0, func, a, b);
        acceptOn(0, tag);
        waitResponse(tag, expLat, 1'b0, expRes, expOv, expZero, expErr);
        tick();
        checkOutput({tag, "_done"}, {30'd0, busy, rsp_valid}, 32'd0);
    endtask

    initial begin
        rst_n = 1'b0; rsp_ready = 1'b1;
        req0_valid = 1'b0; req0_func = 4'd0; req0_a = 32'd0; req0_b = 32'd0;
        req1_valid = 1'b0; req1_func = 4'd0; req1_a = 32'd0; req1_b = 32'd0;
        resetDut();

        oneOp("add_5_7", FUNC_ADD, 32'd5, 32'd7, 1, 32'd12, 1'b0, 1'b0, 1'b0);
        oneOp("add_ovf", FUNC_ADD, 32'h7FFF_FFFF, 32'd1, 1, 32'h8000_0000, 1'b1, 1'b0, 1'b0);
        oneOp("sub_zero", FUNC_SUB, 32'd3, 32'd3, 1, 32'd0, 1'b0, 1'b1, 1'b0);

        // Contested requests right after reset, twice, then a lone port-1 request.
        resetDut();
        for (int rep = 0; rep < 2; rep++) begin
            applyStimulus(0, FUNC_AND, 32'hF0, 32'h3C);
            applyStimulus(1, FUNC_OR, 32'hF0, 32'h0F);
            acceptOn(0, "arb_first");
            waitResponse("arb_p0", 1, 1'b0, 32'h30, 1'b0, 1'b0, 1'b0);
            tick();
            acceptOn(1, "arb_second");
            waitResponse("arb_p1", 1, 1'b1, 32'hFF, 1'b0, 1'b0, 1'b0);
            tick();
        end
        applyStimulus(1, FUNC_ADD, 32'd2, 32'd3);
        acceptOn(1, "solo_p1");
        waitResponse("solo_p1", 1, 1'b1, 32'd5, 1'b0, 1'b0, 1'b0);
        tick();

        oneOp("div_by0", FUNC_DIV, 32'd7, 32'd0, DIV_LAT, 32'd0, 1'b1, 1'b1, 1'b0);
        oneOp("div_min", FUNC_DIV, INT_MIN, NEG_ONE, DIV_LAT, INT_MIN, 1'b1, 1'b0, 1'b0);
        oneOp("div_neg", FUNC_DIV, 32'hFFFF_FFF9, 32'd2, DIV_LAT, 32'hFFFF_FFFD, 1'b0, 1'b0, 1'b0);

        // Response back-pressure with both ports asking during the stall.
        rsp_ready = 1'b0;
        applyStimulus(0, FUNC_MUL, 32'h1_0000, 32'h1_0000);
        acceptOn(0, "mul_stall");
        waitResponse("mul_stall", MUL_LAT, 1'b0, 32'd0, 1'b0, 1'b1, 1'b0);
        applyStimulus(0, FUNC_ADD, 32'd1, 32'd1);
        applyStimulus(1, FUNC_ADD, 32'd1, 32'd1);
        for (int i = 0; i < 4; i++) begin
            tick();
            checkOutput("stall_valid", {31'd0, rsp_valid}, 32'd1);
            checkOutput("stall_result", rsp_result, 32'd0);
            checkOutput("stall_flags", {29'd0, rsp_overflow, rsp_zero, rsp_error}, 32'd2);
            checkOutput("stall_readys", {30'd0, req1_ready, req0_ready}, 32'd0);
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        rsp_ready  = 1'b1;
        tick();
        checkOutput("stall_release", {31'd0, rsp_valid}, 32'd0);

        // Reset in the middle of a divide discards it.
        applyStimulus(0, FUNC_DIV, 32'd100, 32'd5);
        acceptOn(0, "div_abort");
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        checkOutput("abort_idle", {30'd0, busy, rsp_valid}, 32'd0);
        oneOp("after_abort", FUNC_ADD, 32'd1, 32'd1, 1, 32'd2, 1'b0, 1'b0, 1'b0);

        oneOp("bad_func", 4'b1010, 32'd9, 32'd9, 1, 32'd0, 1'b0, 1'b1, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", numChecks, numFails);
        $finish;
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: observed timeout expected completion");
        $fatal(1, "[TB] simulation timeout");
    end

endmodule

// File: doc/ula_sched.md
# ula_sched

Shared-ALU scheduler for the core's execute stage. Two requesters (port 0: integer pipeline, port 1: auxiliary unit such as address or branch helper) share one `ula` instance. The block arbitrates round-robin and holds operands stable for a per-operation multicycle window. Each result is returned with cleaned-up flags over a valid/ready response channel. Multiply and divide are timed as multicycle paths, so only add/sub/and/or close in one cycle.

## Interface
- `MUL_LAT`, 2: cycles operands are held for func 0010 (≥1)
- `DIV_LAT`, 4: cycles operands are held for func 0011 (≥1)
- `clk`  in  1  single clock, rising edge
- `rst_n`  in  1  synchronous, active-low reset
- `req0_valid`  in  1  port 0 request
- `req0_ready`  out  1  port 0 accepted this cycle
- `req0_func`  in  4  operation code
- `req0_a`, `req0_b`  in  32  signed operands
- `req1_valid`, `req1_ready`, `req1_func`, `req1_a`, `req1_b`: same as port 0
- `rsp_valid`  out  1  response available
- `rsp_ready`  in  1  consumer takes response
- `rsp_id`  out  1  port that issued the operation
- `rsp_result`  out  32  signed result
- `rsp_overflow`  out  1  overflow / divide fault
- `rsp_zero`  out  1  `rsp_result == 0`
- `rsp_error`  out  1  unsupported func code
- `busy`  out  1  state != IDLE

## Operation
- Func codes: 0000 add, 0001 sub, 0010 mul (low 32 bits), 0011 signed div (truncating), 0100 and, 0101 or. 0110–1111 are invalid.
- FSM states: IDLE → EXEC → RESP → IDLE.
- **IDLE**
  - Grant goes to the only valid port.
  - If both ports are valid, grant goes to the port not granted last. The `last` pointer resets to 1, so port 0 wins first.
  - `reqN_ready` = (state == IDLE) && grant == N. It is combinational from the valid inputs.
  - On handshake: capture func/a/b/id, load the counter with the latency minus 1, go to EXEC.
- **EXEC**
  - Captured operands drive `ula`.
  - Counter decrements each cycle.
  - At counter 0: register result and flags into the `rsp_*` regs, go to RESP.
- **RESP**
  - `rsp_valid` = 1. Payload is held stable until `rsp_ready`.
  - On handshake go to IDLE. No request is accepted in RESP.
- Latency: 1 for add/sub/and/or/invalid, `MUL_LAT` for mul, `DIV_LAT` for div.
- Flag rules (the controller overrides raw ALU flags):
  - add/sub: signed two's-complement overflow.
  - mul: overflow = 0.
  - and/or: overflow = 0.
  - div with b == 0: result = 0, overflow = 1.
  - div 0x80000000 / −1: result = 0x80000000, overflow = 1.
  - Invalid func: result = 0, overflow = 0, error = 1.
  - Zero flag is always computed from the final `rsp_result`.
- Requesters must hold valid and payload until ready. Payload is sampled only on handshake.

## Timing
- Accept in cycle 0 → EXEC for cycles 1..L → `rsp_valid` first high in cycle L+1.
- With `rsp_ready` tied to 1, an add round-trip is 3 cycles: the next accept is possible in cycle L+2.
- Reset values: state IDLE; `rsp_valid` 0; `rsp_result` 0; `rsp_overflow`, `rsp_zero`, `rsp_error`, `rsp_id` all 0; `busy` 0; `reqN_ready` 0 while `rst_n` = 0; `last` 1.
- Reset asserted in any state: the operation is discarded, with no response and no stale `rsp_valid` after release. The first cycle after release is IDLE and can accept.
- Simultaneous valids on consecutive issues alternate strictly between the ports.
- A single persistent requester is granted every issue slot.
- A valid that drops before ready is not recorded, and `last` is unchanged.

## Structure
- Package `ula_pkg`:
  - func code constants (`FUNC_ADD` … `FUNC_OR`);
  - FSM state encoding;
  - default latency constants;
  - localparams `INT_MIN` = 32'h80000000 and `NEG_ONE` = 32'hFFFFFFFF.
- Sub-module: one `ula` instance, driven only from the captured operand registers. Divide-by-zero and INT_MIN/−1 are decoded in this block so the ALU output is never used for those cases.
- Latency counter width: clog2(max(`MUL_LAT`, `DIV_LAT`)) + 1.

## Test plan
- req0 add 5 + 7, `rsp_ready` = 1 → `rsp_valid` in cycle 2 after accept: result 12, zero 0, overflow 0, id 0, `busy` high cycles 1–2.
- req0 add 0x7FFFFFFF + 1 → result 0x80000000, overflow 1. sub 3 − 3 → result 0, zero 1.
- Both valid after reset: req0 and 0xF0 & 0x3C, req1 or 0xF0 | 0x0F.
  - Required order: id 0 (0x30), then id 1 (0xFF).
  - Repeat both → id 0 then id 1 again. Only req1 valid → granted immediately.
- div cases, each with `rsp_valid` exactly `DIV_LAT` + 1 cycles after accept:
  - 7 / 0 → result 0, overflow 1.
  - 0x80000000 / −1 → 0x80000000, overflow 1.
  - −7 / 2 → 0xFFFFFFFD (−3), overflow 0.
- mul 0x10000 * 0x10000 with `rsp_ready` low for 5 cycles → result 0, zero 1, overflow 0. Payload is stable throughout and both `reqN_ready` stay 0 until the handshake.
- Two cases:
  - `rst_n` low for one cycle during div EXEC → no response appears, and IDLE with ready is available the next cycle.
  - func 1010 → result 0, error 1, zero 1, latency 1.
